alu_exec_unit: RTL and testbench

//  EX-stage arithmetic block of the 5-stage MIPS pipeline CPU.
//  - Decodes ALUOp/funct into a 3-bit ALU control code.
//  - Runs the 32-bit ALU and a sync-reset result register.
//  - Holds the two PC adders: PC+4 and branch target.
//  - Sits between the ID/EX pipeline register and the EX/MEM pipeline register.

---
 rtl/alu_exec_unit_pkg.sv | 26 ++
 rtl/alu_exec_unit_if.sv | 32 +++
 rtl/alu_exec_unit_adder32.sv | 15 +
 rtl/alu_exec_unit.sv | 94 +++++++++
 tb/tb_alu_exec_unit.sv | 116 +++++++++++
 5 files changed

// File: rtl/alu_exec_unit_pkg.sv
// rtl/alu_exec_unit_pkg.sv - shared ALU control, ALUOp and funct constants
package alu_exec_unit_pkg;

  // ALU control codes driven by the decoder into the ALU
  localparam logic [2:0] CTRL_AND = 3'b000;
  localparam logic [2:0] CTRL_OR  = 3'b001;
  localparam logic [2:0] CTRL_ADD = 3'b010;
  localparam logic [2:0] CTRL_MUL = 3'b011;
  localparam logic [2:0] CTRL_SUB = 3'b110;
  localparam logic [2:0] CTRL_SLT = 3'b111;

  // ALUOp values from the main Control unit
  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BEQ   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ADDI  = 2'b11;

  // R-type funct field values
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - EX-stage operand/result bundle between ID/EX and EX/MEM
interface alu_exec_unit_if #(
  parameter int W = 32
) ();

  logic         stall_i;
  logic [1:0]   alu_op_i;
  logic [5:0]   funct_i;
  logic [W-1:0] data1_i;
  logic [W-1:0] data2_i;
  logic [W-1:0] pc_i;
  logic [W-1:0] imm_i;
  logic [2:0]   alu_ctrl_o;
  logic [W-1:0] result_o;
  logic         zero_o;
  logic [W-1:0] result_q_o;
  logic [W-1:0] pc4_o;
  logic [W-1:0] branch_target_o;

  // Pipeline side that feeds operands and consumes results
  modport master (
    output stall_i, alu_op_i, funct_i, data1_i, data2_i, pc_i, imm_i,
    input  alu_ctrl_o, result_o, zero_o, result_q_o, pc4_o, branch_target_o
  );

  // Execution unit side
  modport slave (
    input  stall_i, alu_op_i, funct_i, data1_i, data2_i, pc_i, imm_i,
    output alu_ctrl_o, result_o, zero_o, result_q_o, pc4_o, branch_target_o
  );

endinterface

// File: rtl/alu_exec_unit_adder32.sv
// rtl/alu_exec_unit_adder32.sv - W-wide wrapping adder used for the PC paths
module adder32 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);

  // Plain modulo-2^W sum; carry out is intentionally discarded
  always_comb begin
    sum_o = a_i + b_i;
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - EX-stage ALU decode, ALU, result register and PC adders
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int           W      = 32,
  parameter logic [W-1:0] PC_INC = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  alu_exec_unit_if.slave  bus
);

  logic [2:0]   alu_ctrl;
  logic [W-1:0] alu_result;
  logic [W-1:0] res_d;
  logic [W-1:0] res_q;
  logic [W-1:0] pc4;
  logic [W-1:0] imm_shift;

  // Translate ALUOp/funct into the 3-bit ALU control code; unknown funct falls back to ADD
  always_comb begin
    alu_ctrl = CTRL_ADD;
    unique case (bus.alu_op_i)
      ALUOP_MEM:  alu_ctrl = CTRL_ADD;
      ALUOP_BEQ:  alu_ctrl = CTRL_SUB;
      ALUOP_ADDI: alu_ctrl = CTRL_ADD;
      ALUOP_RTYPE: begin
        case (bus.funct_i)
          FUNCT_ADD: alu_ctrl = CTRL_ADD;
          FUNCT_SUB: alu_ctrl = CTRL_SUB;
          FUNCT_AND: alu_ctrl = CTRL_AND;
          FUNCT_OR:  alu_ctrl = CTRL_OR;
          FUNCT_MUL: alu_ctrl = CTRL_MUL;
          FUNCT_SLT: alu_ctrl = CTRL_SLT;
          default:   alu_ctrl = CTRL_ADD;
        endcase
      end
      default:    alu_ctrl = CTRL_ADD;
    endcase
  end

  // Zero-latency ALU; arithmetic wraps, MUL keeps the low W bits, unused codes give 0
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      CTRL_AND: alu_result = bus.data1_i & bus.data2_i;
      CTRL_OR:  alu_result = bus.data1_i | bus.data2_i;
      CTRL_ADD: alu_result = bus.data1_i + bus.data2_i;
      CTRL_MUL: alu_result = bus.data1_i * bus.data2_i;
      CTRL_SUB: alu_result = bus.data1_i - bus.data2_i;
      CTRL_SLT: alu_result = ($signed(bus.data1_i) < $signed(bus.data2_i)) ? W'(1) : W'(0);
      default:  alu_result = '0;
    endcase
  end

  // Next result-register value: reset clears, stall holds, otherwise capture the ALU
  always_comb begin
    res_d = res_q;
    if (rst_i) begin
      res_d = '0;
    end else if (!bus.stall_i) begin
      res_d = alu_result;
    end
  end

  // Result register toward EX/MEM
  always_ff @(posedge clk_i) begin
    res_q <= res_d;
  end

  // Branch offset is the word immediate; top two bits fall off the end
  always_comb begin
    imm_shift = {bus.imm_i[W-3:0], 2'b00};
  end

  adder32 #(.W(W)) u_pc4_add (
    .a_i   (bus.pc_i),
    .b_i   (PC_INC),
    .sum_o (pc4)
  );

  adder32 #(.W(W)) u_branch_add (
    .a_i   (pc4),
    .b_i   (imm_shift),
    .sum_o (bus.branch_target_o)
  );

  assign bus.alu_ctrl_o = alu_ctrl;
  assign bus.result_o   = alu_result;
  assign bus.zero_o     = (alu_result == '0);
  assign bus.result_q_o = res_q;
  assign bus.pc4_o      = pc4;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

  logic clk_i = 1'b0;
  logic rst_i;

  always #5 clk_i = ~clk_i;

  alu_exec_unit_if #(.W(32)) bus ();

  alu_exec_unit #(.W(32), .PC_INC(32'd4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] sb_q[$];
  logic [31:0] model_q = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one operation after the falling edge, check the combinational outputs,
  // queue the expected register value, then pop it after the next rising edge.
  task automatic ex(input string tag, input logic [1:0] op, input logic [5:0] funct,
                    input logic [31:0] a, input logic [31:0] b,
                    input logic [2:0] exp_ctrl, input logic [31:0] exp_res);
    logic [31:0] exp_q;
    @(negedge clk_i);
    bus.alu_op_i = op;
    bus.funct_i  = funct;
    bus.data1_i  = a;
    bus.data2_i  = b;
    #1;
    chk({tag, "_ctrl"}, {29'd0, bus.alu_ctrl_o}, {29'd0, exp_ctrl});
    chk({tag, "_res"}, bus.result_o, exp_res);
    chk({tag, "_zero"}, {31'd0, bus.zero_o}, {31'd0, (exp_res == 32'h0)});
    if (rst_i) model_q = 32'h0;
    else if (!bus.stall_i) model_q = exp_res;
    sb_q.push_back(model_q);
    @(posedge clk_i);
    #1;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_q observed=empty_scoreboard expected=entry", tag);
    end else begin
      exp_q = sb_q.pop_front();
      chk({tag, "_q"}, bus.result_q_o, exp_q);
    end
  endtask

  task automatic pc_chk(input string tag, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] exp_pc4, input logic [31:0] exp_bt);
    bus.pc_i  = pc;
    bus.imm_i = imm;
    #1;
    chk({tag, "_pc4"}, bus.pc4_o, exp_pc4);
    chk({tag, "_bt"}, bus.branch_target_o, exp_bt);
  endtask

  initial begin
    rst_i        = 1'b1;
    bus.stall_i  = 1'b0;
    bus.alu_op_i = 2'b00;
    bus.funct_i  = 6'd0;
    bus.data1_i  = 32'd0;
    bus.data2_i  = 32'd0;
    bus.pc_i     = 32'd0;
    bus.imm_i    = 32'd0;

    // Reset: register clears while the combinational path stays live
    ex("rst_add", 2'b10, 6'b100000, 32'd7, 32'd5, 3'b010, 32'd12);

    rst_i = 1'b0;
    ex("add", 2'b10, 6'b100000, 32'd7, 32'd5, 3'b010, 32'd12);
    ex("beq_eq", 2'b01, 6'b000000, 32'h1234, 32'h1234, 3'b110, 32'h0);
    ex("beq_wrap", 2'b01, 6'b000000, 32'h0, 32'h1, 3'b110, 32'hFFFF_FFFF);
    ex("lw_add", 2'b00, 6'b101010, 32'd100, 32'd8, 3'b010, 32'd108);
    ex("addi", 2'b11, 6'b100010, 32'hFFFF_FFFF, 32'd2, 3'b010, 32'd1);
    ex("rsub", 2'b10, 6'b100010, 32'd10, 32'd3, 3'b110, 32'd7);
    ex("and", 2'b10, 6'b100100, 32'hF0F0, 32'h0FF0, 3'b000, 32'h00F0);
    ex("or", 2'b10, 6'b100101, 32'hF0F0, 32'h0FF0, 3'b001, 32'hFFF0);
    ex("mul_ovf", 2'b10, 6'b011000, 32'h1_0000, 32'h1_0000, 3'b011, 32'h0);
    ex("mul_neg", 2'b10, 6'b011000, 32'hFFFF_FFFD, 32'd4, 3'b011, 32'hFFFF_FFF4);
    ex("slt_lt", 2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 3'b111, 32'd1);
    ex("slt_ge", 2'b10, 6'b101010, 32'd1, 32'hFFFF_FFFF, 3'b111, 32'd0);
    ex("unk_funct", 2'b10, 6'b111111, 32'd2, 32'd3, 3'b010, 32'd5);

    // Register sequence: load, stall holds, reset beats stall
    ex("seq_load", 2'b10, 6'b100000, 32'd7, 32'd5, 3'b010, 32'd12);
    bus.stall_i = 1'b1;
    ex("seq_stall", 2'b10, 6'b100000, 32'd2, 32'd3, 3'b010, 32'd5);
    rst_i = 1'b1;
    ex("seq_rst_stall", 2'b10, 6'b100000, 32'd2, 32'd3, 3'b010, 32'd5);
    rst_i       = 1'b0;
    bus.stall_i = 1'b0;
    ex("seq_resume", 2'b10, 6'b100000, 32'd2, 32'd3, 3'b010, 32'd5);

    // PC adders
    pc_chk("pc_back", 32'h100, 32'hFFFF_FFFE, 32'h104, 32'hFC);
    pc_chk("pc_wrap", 32'hFFFF_FFFC, 32'h1, 32'h0, 32'h4);
    pc_chk("pc_immtop", 32'h0, 32'h4000_0001, 32'h4, 32'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
